biriscv_inst_queue: RTL

Instruction queue directly downstream of the fetch stage. It accepts 64-bit fetch bundles (two 32-bit instruction slots with PC, branch prediction and fault flags) and splits them into individual instructions. It buffers them in a circular FIFO and presents up to two in-order instructions per cycle to dual-issue decode. Flush support discards all buffered instructions on a branch or pipeline redirect.

---
 rtl/biriscv_inst_queue_if.sv | 48 ++++
 rtl/biriscv_inst_queue.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/biriscv_inst_queue_if.sv
// Fetch-to-decode handshake bundle for the instruction queue.
// The slave side is the queue itself; the master side is fetch plus decode.
interface biriscv_inst_queue_if;
  logic        flush_i;
  logic        in_valid_i;
  logic [63:0] in_instr_i;
  logic [31:0] in_pc_i;
  logic [1:0]  in_pred_i;
  logic        in_fault_fetch_i;
  logic        in_fault_page_i;
  logic        in_accept_o;

  logic        out0_valid_o;
  logic [31:0] out0_instr_o;
  logic [31:0] out0_pc_o;
  logic        out0_pred_o;
  logic        out0_fault_fetch_o;
  logic        out0_fault_page_o;
  logic        out0_accept_i;

  logic        out1_valid_o;
  logic [31:0] out1_instr_o;
  logic [31:0] out1_pc_o;
  logic        out1_pred_o;
  logic        out1_fault_fetch_o;
  logic        out1_fault_page_o;
  logic        out1_accept_i;

  modport slave (
    input  flush_i, in_valid_i, in_instr_i, in_pc_i, in_pred_i,
    input  in_fault_fetch_i, in_fault_page_i, out0_accept_i, out1_accept_i,
    output in_accept_o,
    output out0_valid_o, out0_instr_o, out0_pc_o, out0_pred_o,
    output out0_fault_fetch_o, out0_fault_page_o,
    output out1_valid_o, out1_instr_o, out1_pc_o, out1_pred_o,
    output out1_fault_fetch_o, out1_fault_page_o
  );

  modport master (
    output flush_i, in_valid_i, in_instr_i, in_pc_i, in_pred_i,
    output in_fault_fetch_i, in_fault_page_i, out0_accept_i, out1_accept_i,
    input  in_accept_o,
    input  out0_valid_o, out0_instr_o, out0_pc_o, out0_pred_o,
    input  out0_fault_fetch_o, out0_fault_page_o,
    input  out1_valid_o, out1_instr_o, out1_pc_o, out1_pred_o,
    input  out1_fault_fetch_o, out1_fault_page_o
  );
endinterface

// File: rtl/biriscv_inst_queue.sv
// Instruction queue: splits 64-bit fetch bundles into 32-bit instructions, buffers them in a
// circular FIFO and presents up to two in-order instructions per cycle to dual-issue decode.
module biriscv_inst_queue #(
  parameter int unsigned DEPTH = 8
) (
  input logic                  clk_i,
  input logic                  rst_i,
  biriscv_inst_queue_if.slave  q_if
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  typedef struct packed {
    logic [31:0] instr;
    logic [29:0] pc;
    logic        pred;
    logic        fault_fetch;
    logic        fault_page;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_inc, rd_ptr_inc;
  logic [CntW-1:0] count_q, count_d;
  logic [CntW-1:0] space;
  logic [CntW-1:0] push_cnt, pop_cnt;

  logic   accept;
  logic   valid0, valid1;
  logic   slot0_en, slot1_en;
  logic   push_en, wr0_en, wr1_en;
  logic   pop0, pop1;
  entry_t slot0_e, slot1_e, wr0_e;
  entry_t head0_e, head1_e;

  // Low PC bits are implied by slot position; only bit 2 matters.
  logic unused_pc;
  assign unused_pc = ^q_if.in_pc_i[1:0];

  assign wr_ptr_inc = wr_ptr_q + PtrW'(1);
  assign rd_ptr_inc = rd_ptr_q + PtrW'(1);

  // Acceptance uses the registered count only, so it never waits on decode.
  assign space  = DepthCnt - count_q;
  assign accept = (space >= CntW'(2)) & ~q_if.flush_i;
  assign valid0 = (count_q != '0) & ~q_if.flush_i;
  assign valid1 = (count_q > CntW'(1)) & ~q_if.flush_i;

  always_comb begin
    slot0_e = '{
      instr:       q_if.in_instr_i[31:0],
      pc:          {q_if.in_pc_i[31:3], 1'b0},
      pred:        q_if.in_pred_i[0],
      fault_fetch: q_if.in_fault_fetch_i,
      fault_page:  q_if.in_fault_page_i
    };
    slot1_e = '{
      instr:       q_if.in_instr_i[63:32],
      pc:          {q_if.in_pc_i[31:3], 1'b1},
      pred:        q_if.in_pred_i[1],
      fault_fetch: q_if.in_fault_fetch_i,
      fault_page:  q_if.in_fault_page_i
    };
  end

  // A predicted-taken slot0 redirects fetch, so slot1 is off the path.
  assign slot0_en = ~q_if.in_pc_i[2];
  assign slot1_en = ~(slot0_en & q_if.in_pred_i[0]);

  assign push_en = q_if.in_valid_i & accept;
  assign wr0_en  = push_en & (slot0_en | slot1_en);
  assign wr1_en  = push_en & slot0_en & slot1_en;
  assign wr0_e   = slot0_en ? slot0_e : slot1_e;

  assign pop0 = valid0 & q_if.out0_accept_i;
  assign pop1 = valid1 & q_if.out1_accept_i & pop0;

  assign push_cnt = CntW'(wr0_en) + CntW'(wr1_en);
  assign pop_cnt  = CntW'(pop0) + CntW'(pop1);

  always_comb begin
    count_d  = count_q + push_cnt - pop_cnt;
    wr_ptr_d = wr_ptr_q + PtrW'(push_cnt);
    rd_ptr_d = rd_ptr_q + PtrW'(pop_cnt);
    if (q_if.flush_i) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (wr0_en) begin
        mem_q[wr_ptr_q] <= wr0_e;
      end
      if (wr1_en) begin
        mem_q[wr_ptr_inc] <= slot1_e;
      end
    end
  end

  assign head0_e = mem_q[rd_ptr_q];
  assign head1_e = mem_q[rd_ptr_inc];

  assign q_if.in_accept_o        = accept;

  assign q_if.out0_valid_o       = valid0;
  assign q_if.out0_instr_o       = head0_e.instr;
  assign q_if.out0_pc_o          = {head0_e.pc, 2'b00};
  assign q_if.out0_pred_o        = head0_e.pred;
  assign q_if.out0_fault_fetch_o = head0_e.fault_fetch;
  assign q_if.out0_fault_page_o  = head0_e.fault_page;

  assign q_if.out1_valid_o       = valid1;
  assign q_if.out1_instr_o       = head1_e.instr;
  assign q_if.out1_pc_o          = {head1_e.pc, 2'b00};
  assign q_if.out1_pred_o        = head1_e.pred;
  assign q_if.out1_fault_fetch_o = head1_e.fault_fetch;
  assign q_if.out1_fault_page_o  = head1_e.fault_page;

endmodule
